// File: rtl/ahb_cmd_arbiter_if.sv
// ahb_cmd_arbiter_if: requester, master-command and response signals shared by the arbiter and its environment
interface ahb_cmd_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int GW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ*8-1:0]          req_len;
    logic [NUM_REQ*3-1:0]          req_size;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic                          m_cmd_valid;
    logic                          m_cmd_write;
    logic [ADDR_WIDTH-1:0]         m_cmd_addr;
    logic [DATA_WIDTH-1:0]         m_cmd_wdata;
    logic [7:0]                    m_cmd_len;
    logic [2:0]                    m_cmd_size;
    logic                          m_cmd_ready;
    logic                          m_resp_valid;
    logic [DATA_WIDTH-1:0]         m_resp_rdata;
    logic                          m_resp_err;
    logic [GW-1:0]                 grant_id;
    logic                          busy;
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_len, req_size,
        input  m_cmd_ready, m_resp_valid, m_resp_rdata, m_resp_err,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output m_cmd_valid, m_cmd_write, m_cmd_addr, m_cmd_wdata, m_cmd_len, m_cmd_size,
        output grant_id, busy
    );
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_len, req_size,
        output m_cmd_ready, m_resp_valid, m_resp_rdata, m_resp_err,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  m_cmd_valid, m_cmd_write, m_cmd_addr, m_cmd_wdata, m_cmd_len, m_cmd_size,
        input  grant_id, busy
    );
endinterface

// File: rtl/ahb_cmd_arbiter.sv
// ahb_cmd_arbiter: round-robin sharing of one AHB-Lite command/response master among NUM_REQ requesters
module ahb_cmd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input logic              HCLK,
    input logic              HRESETn,
    ahb_cmd_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {ARB, ISSUE, WAIT_RESP} state_t;
    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] pick;
    logic          any;
    logic [WW-1:0] wd;
    int            j;
    // rotating priority search starting just after the previous owner
    always_comb begin
        pick = '0;
        any  = 1'b0;
        j    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(last_grant) + k) % NUM_REQ;
            if (!any && bus.req_valid[j]) begin
                any  = 1'b1;
                pick = GW'(j);
            end
        end
    end
    assign bus.req_ready = (state == ARB && any) ? NUM_REQ'(1) << pick : '0;
    // command/response sequencing with a watchdog that only runs while awaiting completion
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state           <= ARB;
            last_grant      <= GW'(NUM_REQ - 1);
            wd              <= '0;
            bus.grant_id    <= '0;
            bus.busy        <= 1'b0;
            bus.rsp_valid   <= '0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.m_cmd_valid <= 1'b0;
            bus.m_cmd_write <= 1'b0;
            bus.m_cmd_addr  <= '0;
            bus.m_cmd_wdata <= '0;
            bus.m_cmd_len   <= '0;
            bus.m_cmd_size  <= '0;
        end else begin
            bus.rsp_valid <= '0;
            case (state)
                ARB: if (any) begin
                    bus.m_cmd_write <= bus.req_write[pick];
                    bus.m_cmd_addr  <= bus.req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    bus.m_cmd_wdata <= bus.req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
                    bus.m_cmd_len   <= bus.req_len[pick*8 +: 8];
                    bus.m_cmd_size  <= bus.req_size[pick*3 +: 3];
                    bus.m_cmd_valid <= 1'b1;
                    bus.grant_id    <= pick;
                    bus.busy        <= 1'b1;
                    last_grant      <= pick;
                    state           <= ISSUE;
                end
                ISSUE: if (bus.m_cmd_ready) begin
                    bus.m_cmd_valid <= 1'b0;
                    wd              <= '0;
                    state           <= WAIT_RESP;
                end
                WAIT_RESP: if (bus.m_resp_valid || wd == WW'(TIMEOUT - 1)) begin
                    bus.rsp_valid <= NUM_REQ'(1) << bus.grant_id;
                    bus.rsp_rdata <= bus.m_resp_valid ? bus.m_resp_rdata : '0;
                    bus.rsp_err   <= bus.m_resp_valid ? bus.m_resp_err : 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= ARB;
                end else begin
                    wd <= wd + 1'b1;
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_cmd_arbiter.sv
// tb_ahb_cmd_arbiter: vector table, corner sequences and randomized transactions against a round-robin model
module tb_ahb_cmd_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int checks = 0;
    int errors = 0;
    int last = N - 1;
    logic [31:0] cur_addr;
    ahb_cmd_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    ahb_cmd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus)
    );
    always #5 HCLK = ~HCLK;
    typedef struct {
        logic [3:0]  mask;
        int          rdy;
        int          rsp;
        logic [31:0] rdata;
        logic        err;
        int          grant;
    } vec_t;
    vec_t tbl[12];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask
    function automatic int model_pick(input logic [3:0] m, input int lg);
        for (int d = 1; d <= N; d++)
            if (m[(lg + d) % N]) return (lg + d) % N;
        return -1;
    endfunction
    task automatic accept(input logic [3:0] mask, input int exp);
        logic [31:0] a[N];
        logic [31:0] w[N];
        logic [7:0]  l[N];
        logic [2:0]  s[N];
        logic        wr[N];
        for (int i = 0; i < N; i++) begin
            a[i] = $urandom; w[i] = $urandom; l[i] = 8'($urandom_range(0, 255));
            s[i] = 3'($urandom_range(0, 7)); wr[i] = 1'($urandom_range(0, 1));
            bus.req_addr[i*32 +: 32] = a[i];
            bus.req_wdata[i*32 +: 32] = w[i];
            bus.req_len[i*8 +: 8] = l[i];
            bus.req_size[i*3 +: 3] = s[i];
            bus.req_write[i] = wr[i];
        end
        bus.req_valid = mask;
        #1;
        chk("req_ready", 64'(bus.req_ready), 64'(4'b1 << exp));
        @(posedge HCLK); #1;
        bus.req_valid = '0;
        cur_addr = a[exp];
        chk("cmd_valid", 64'(bus.m_cmd_valid), 64'd1);
        chk("cmd_addr", 64'(bus.m_cmd_addr), 64'(a[exp]));
        chk("cmd_wdata", 64'(bus.m_cmd_wdata), 64'(w[exp]));
        chk("cmd_len", 64'(bus.m_cmd_len), 64'(l[exp]));
        chk("cmd_size", 64'(bus.m_cmd_size), 64'(s[exp]));
        chk("cmd_write", 64'(bus.m_cmd_write), 64'(wr[exp]));
        chk("grant_id", 64'(bus.grant_id), 64'(exp));
        chk("busy_set", 64'(bus.busy), 64'd1);
        last = exp;
    endtask
    task automatic issue(input int dly);
        repeat (dly) begin
            @(posedge HCLK); #1;
            chk("cmd_hold", 64'(bus.m_cmd_valid), 64'd1);
            chk("cmd_stable", 64'(bus.m_cmd_addr), 64'(cur_addr));
        end
        bus.m_cmd_ready = 1'b1;
        @(posedge HCLK); #1;
        bus.m_cmd_ready = 1'b0;
        chk("cmd_drop", 64'(bus.m_cmd_valid), 64'd0);
        chk("busy_wait", 64'(bus.busy), 64'd1);
    endtask
    task automatic respond(input int rd, input logic [31:0] rdata, input logic err, input int owner);
        bus.m_resp_rdata = rdata;
        bus.m_resp_err = err;
        for (int c = 0; c < TO; c++) begin
            bus.m_resp_valid = (c == rd);
            @(posedge HCLK); #1;
            bus.m_resp_valid = 1'b0;
            if (c == rd || c == TO - 1) begin
                chk("rsp_valid", 64'(bus.rsp_valid), 64'(4'b1 << owner));
                chk("rsp_err", 64'(bus.rsp_err), 64'(c == rd ? err : 1'b1));
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(c == rd ? rdata : 32'h0));
                chk("busy_clr", 64'(bus.busy), 64'd0);
                break;
            end
            chk("rsp_quiet", 64'(bus.rsp_valid), 64'd0);
        end
        @(posedge HCLK); #1;
        chk("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
    endtask
    initial begin
        bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_len = '0; bus.req_size = '0; bus.m_cmd_ready = 1'b0; bus.m_resp_valid = 1'b0;
        bus.m_resp_rdata = '0; bus.m_resp_err = 1'b0;
        tbl[0]  = '{4'b0001, 0,  2, 32'h0000_1234, 1'b0, 0};
        tbl[1]  = '{4'b1111, 2,  3, 32'h1111_1111, 1'b0, 1};
        tbl[2]  = '{4'b1111, 0,  3, 32'h2222_2222, 1'b0, 2};
        tbl[3]  = '{4'b1111, 1,  3, 32'h3333_3333, 1'b0, 3};
        tbl[4]  = '{4'b1111, 0,  3, 32'h4444_4444, 1'b0, 0};
        tbl[5]  = '{4'b1001, 0,  1, 32'h5555_5555, 1'b0, 3};
        tbl[6]  = '{4'b1001, 0,  0, 32'h6666_6666, 1'b0, 0};
        tbl[7]  = '{4'b1001, 3,  4, 32'h7777_7777, 1'b0, 3};
        tbl[8]  = '{4'b0100, 0,  1, 32'hDEAD_BEEF, 1'b1, 2};
        tbl[9]  = '{4'b0010, 0, 99, 32'h0000_0055, 1'b0, 1};
        tbl[10] = '{4'b1000, 0, 15, 32'hA5A5_A5A5, 1'b0, 3};
        tbl[11] = '{4'b0110, 40, 0, 32'h0BAD_CAFE, 1'b1, 1};
        @(posedge HCLK); #1;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'd0);
        chk("rst_cmd", 64'({bus.m_cmd_valid, bus.m_cmd_write, bus.m_cmd_len, bus.m_cmd_size}), 64'd0);
        chk("rst_addr", 64'({bus.m_cmd_addr, bus.m_cmd_wdata}), 64'd0);
        chk("rst_gid", 64'({bus.grant_id, bus.busy}), 64'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        for (int n = 0; n < 12; n++) begin
            accept(tbl[n].mask, tbl[n].grant);
            issue(tbl[n].rdy);
            respond(tbl[n].rsp, tbl[n].rdata, tbl[n].err, tbl[n].grant);
        end
        bus.m_resp_valid = 1'b1;
        @(posedge HCLK); #1;
        bus.m_resp_valid = 1'b0;
        @(posedge HCLK); #1;
        chk("stray_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("stray_busy", 64'(bus.busy), 64'd0);
        for (int n = 0; n < 40; n++) begin
            logic [3:0] m;
            int p;
            m = 4'($urandom_range(1, 15));
            p = model_pick(m, last);
            accept(m, p);
            issue($urandom_range(0, 3));
            respond($urandom_range(0, 20), $urandom, 1'($urandom_range(0, 1)), p);
        end
        accept(4'b0100, model_pick(4'b0100, last));
        issue(0);
        repeat (3) @(posedge HCLK);
        #3 HRESETn = 1'b0;
        #1;
        chk("mid_rst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'd0);
        chk("mid_rst_cmd", 64'({bus.m_cmd_valid, bus.m_cmd_addr, bus.m_cmd_len}), 64'd0);
        chk("mid_rst_gid", 64'({bus.grant_id, bus.busy}), 64'd0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        last = N - 1;
        bus.m_resp_valid = 1'b1;
        @(posedge HCLK); #1;
        bus.m_resp_valid = 1'b0;
        chk("no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
        accept(4'b1111, 0);
        issue(0);
        respond(2, 32'hCAFE_F00D, 1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
